// File: rtl/pulse_meter_display.sv
// Pulse-width meter: counts high-pulse width in sysclk cycles, converts to BCD by
// iterative double-dabble, and scans it onto a 4-digit seven-segment display.
// Optional build macro: PMD_LEADING_ZERO_BLANK_EN (blank leading-zero digits).
`timescale 1ns/1ps
module pulse_meter_display #(
  parameter int CNT_W    = 14,
  parameter int SCAN_DIV = 50000,
  parameter int SAT_MAX  = 9999
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       pulse_in,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       meas_done,
  output logic       busy,
  output logic       overrun
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STEP_W = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0]  SAT_VAL   = CNT_W'(SAT_MAX);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CNT_W);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_CONVERT} state_t;

  state_t              r_state;
  logic                r_pulse_d;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_bin;
  logic [15:0]         r_bcd;
  logic [15:0]         r_disp;
  logic [STEP_W-1:0]   r_step;
  logic                r_meas_done;
  logic                r_busy;
  logic                r_overrun;
  logic [SCAN_W-1:0]   r_scan_cnt;
  logic [1:0]          r_idx;

  logic                w_rise;
  logic                w_fall;
  logic [15:0]         w_bcd_adj;
  logic [3:0]          w_nib;
  logic                w_blank;

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  function automatic logic [15:0] dd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign w_rise    = pulse_in & ~r_pulse_d;
  assign w_fall    = ~pulse_in & r_pulse_d;
  assign w_bcd_adj = dd_adjust(r_bcd);

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pulse_d   <= 1'b0;
      r_cnt       <= '0;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_disp      <= '0;
      r_step      <= '0;
      r_meas_done <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_pulse_d   <= pulse_in;
      r_meas_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_cnt   <= CNT_W'(1);
            r_state <= ST_MEASURE;
            r_busy  <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (w_fall) begin
            r_bin   <= r_cnt;
            r_bcd   <= '0;
            r_step  <= '0;
            r_state <= ST_CONVERT;
          end else if (pulse_in && (r_cnt != SAT_VAL)) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_CONVERT: begin
          // A pulse starting while converting is dropped, but remembered.
          if (w_rise) r_overrun <= 1'b1;
          if (r_step == LAST_STEP) begin
            r_disp      <= r_bcd;
            r_meas_done <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_bcd  <= {w_bcd_adj[14:0], r_bin[CNT_W-1]};
            r_bin  <= r_bin << 1;
            r_step <= r_step + STEP_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Digit scan runs in every state; only r_disp changes what is shown.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= 2'd0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  always_comb begin
    w_nib = r_disp[r_idx*4 +: 4];
`ifdef PMD_LEADING_ZERO_BLANK_EN
    case (r_idx)
      2'd1:    w_blank = (r_disp[15:4]  == 12'd0);
      2'd2:    w_blank = (r_disp[15:8]  == 8'd0);
      2'd3:    w_blank = (r_disp[15:12] == 4'd0);
      default: w_blank = 1'b0;
    endcase
`else
    w_blank = 1'b0;
`endif
  end

  assign an        = ~(4'b0001 << r_idx);
  assign seg       = w_blank ? 7'h7F : seg_decode(w_nib);
  assign meas_done = r_meas_done;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule
